// File: rtl/cpu_run_monitor.sv
// rtl/cpu_run_monitor.sv - run-control and self-check monitor for the single-cycle CPU
// Detects halt on a frozen PC, then compares register probes against expected values.
module cpu_run_monitor #(
  parameter int XLEN          = 32,
  parameter int NUM_PROBES    = 1,
  parameter int STABLE_CYCLES = 4,
  parameter int TIMEOUT       = 50000,
  parameter int CNT_W         = $clog2(TIMEOUT + 1)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic [XLEN-1:0]            pc,
  input  logic [NUM_PROBES*XLEN-1:0] probe_data,
  input  logic [NUM_PROBES*XLEN-1:0] exp_data,
  output logic                       busy,
  output logic                       done,
  output logic                       pass,
  output logic                       timeout,
  output logic [NUM_PROBES-1:0]      mismatch,
  output logic [XLEN-1:0]            final_pc,
  output logic [CNT_W-1:0]           cycle_count,
  output logic [CNT_W-1:0]           pc_changes
);

  localparam int SC_W = $clog2(STABLE_CYCLES + 1);
  localparam logic [SC_W-1:0]  STABLE_LAST = SC_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TMO_LAST    = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_CHECK = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                state, state_next;
  logic [XLEN-1:0]       prev_pc;
  logic [SC_W-1:0]       stable_cnt;
  logic                  pc_same;
  logic                  run_start;
  logic                  halt;
  logic                  tmo;
  logic [NUM_PROBES-1:0] probe_miss;

  assign pc_same = (pc == prev_pc);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Halt takes priority over timeout when both land on the same cycle.
  always_comb begin
    state_next = state;
    run_start  = 1'b0;
    halt       = 1'b0;
    tmo        = 1'b0;
    case (state)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_next = S_RUN;
          run_start  = 1'b1;
        end
      end
      S_RUN: begin
        halt = pc_same && (stable_cnt == STABLE_LAST);
        tmo  = !halt && (cycle_count == TMO_LAST);
        if (halt) begin
          state_next = S_CHECK;
        end else if (tmo) begin
          state_next = S_DONE;
        end
      end
      S_CHECK: begin
        state_next = S_DONE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  always_comb begin
    probe_miss = '0;
    for (int i = 0; i < NUM_PROBES; i++) begin
      probe_miss[i] = (probe_data[i*XLEN +: XLEN] != exp_data[i*XLEN +: XLEN]);
    end
  end

  // busy/done are registered from the next state so they change on the same edge as state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy        <= 1'b0;
      done        <= 1'b0;
      pass        <= 1'b0;
      timeout     <= 1'b0;
      mismatch    <= '0;
      final_pc    <= '0;
      cycle_count <= '0;
      pc_changes  <= '0;
      prev_pc     <= '0;
      stable_cnt  <= '0;
    end else begin
      busy <= (state_next == S_RUN) || (state_next == S_CHECK);
      done <= (state_next == S_DONE);
      if (run_start) begin
        pass        <= 1'b0;
        timeout     <= 1'b0;
        mismatch    <= '0;
        final_pc    <= '0;
        cycle_count <= '0;
        pc_changes  <= '0;
        stable_cnt  <= '0;
        prev_pc     <= pc;
      end else if (state == S_RUN) begin
        cycle_count <= cycle_count + 1'b1;
        prev_pc     <= pc;
        if (pc_same) begin
          stable_cnt <= stable_cnt + 1'b1;
        end else begin
          stable_cnt <= '0;
          pc_changes <= pc_changes + 1'b1;
        end
        if (halt) begin
          final_pc <= pc;
        end
        if (tmo) begin
          final_pc <= pc;
          timeout  <= 1'b1;
          pass     <= 1'b0;
        end
      end else if (state == S_CHECK) begin
        mismatch <= probe_miss;
        pass     <= (probe_miss == '0);
      end
    end
  end

endmodule

// File: tb/tb_cpu_run_monitor.sv
// tb/tb_cpu_run_monitor.sv - self-checking bench for cpu_run_monitor
// Directed and random PC traces checked against a trace-walking reference model.
module tb_cpu_run_monitor;

  localparam int XLEN = 32;
  localparam int NP   = 2;
  localparam int SC   = 4;
  localparam int TMO  = 64;
  localparam int CW   = $clog2(TMO + 1);

  logic               clk = 1'b0;
  logic               reset;
  logic               start;
  logic [XLEN-1:0]    pc;
  logic [NP*XLEN-1:0] probe_data;
  logic [NP*XLEN-1:0] exp_data;
  logic               busy, done, pass, timeout;
  logic [NP-1:0]      mismatch;
  logic [XLEN-1:0]    final_pc;
  logic [CW-1:0]      cycle_count, pc_changes;

  int vectors     = 0;
  int miscompares = 0;
  logic [XLEN-1:0] trace[$];

  cpu_run_monitor #(
    .XLEN(XLEN), .NUM_PROBES(NP), .STABLE_CYCLES(SC), .TIMEOUT(TMO)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .pc(pc),
    .probe_data(probe_data), .exp_data(exp_data),
    .busy(busy), .done(done), .pass(pass), .timeout(timeout),
    .mismatch(mismatch), .final_pc(final_pc),
    .cycle_count(cycle_count), .pc_changes(pc_changes)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [XLEN-1:0] tr(input int i);
    return trace[(i < trace.size()) ? i : trace.size() - 1];
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, ".busy"}, 64'(busy), 64'd0);
    check({tag, ".done"}, 64'(done), 64'd0);
    check({tag, ".pass"}, 64'(pass), 64'd0);
    check({tag, ".timeout"}, 64'(timeout), 64'd0);
    check({tag, ".mismatch"}, 64'(mismatch), 64'd0);
    check({tag, ".final_pc"}, 64'(final_pc), 64'd0);
    check({tag, ".cycle_count"}, 64'(cycle_count), 64'd0);
    check({tag, ".pc_changes"}, 64'(pc_changes), 64'd0);
  endtask

  // Reference: walk the trace; halt at the first cycle n whose PC equals the SC preceding values.
  task automatic model(output bit halted, output int n_end, output logic [XLEN-1:0] fpc,
                       output int changes, output logic [NP-1:0] mm);
    halted  = 1'b0;
    n_end   = TMO;
    changes = 0;
    fpc     = tr(TMO);
    for (int n = 1; n <= TMO; n++) begin
      bit win_eq;
      if (tr(n) != tr(n - 1)) changes++;
      win_eq = (n >= SC);
      for (int j = 1; j <= SC && win_eq; j++) begin
        if (tr(n - j) != tr(n)) win_eq = 1'b0;
      end
      if (win_eq) begin
        halted = 1'b1;
        n_end  = n;
        fpc    = tr(n);
        break;
      end
    end
    mm = '0;
    if (halted) begin
      for (int i = 0; i < NP; i++) begin
        mm[i] = (probe_data[i*XLEN +: XLEN] != exp_data[i*XLEN +: XLEN]);
      end
    end
  endtask

  // Caller is positioned #1 after a rising edge with the monitor in IDLE or DONE.
  task automatic do_run(input string tag, input int mid_start, input int abort_at);
    bit              halted;
    int              n_end, changes;
    logic [XLEN-1:0] fpc;
    logic [NP-1:0]   mm;
    bit              got_done;
    model(halted, n_end, fpc, changes, mm);
    pc    = tr(0);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check({tag, ".start_busy"}, 64'(busy), 64'd1);
    check({tag, ".start_done"}, 64'(done), 64'd0);
    check({tag, ".start_cycles"}, 64'(cycle_count), 64'd0);
    check({tag, ".start_timeout"}, 64'(timeout), 64'd0);
    got_done = 1'b0;
    for (int cyc = 1; cyc <= TMO + 8; cyc++) begin
      pc    = tr(cyc);
      start = (cyc == mid_start);
      if (cyc == abort_at) begin
        reset = 1'b0;
        #1;
        check_all_zero({tag, ".abort"});
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check({tag, ".post_abort_done"}, 64'(done), 64'd0);
        check({tag, ".post_abort_busy"}, 64'(busy), 64'd0);
        return;
      end
      @(posedge clk); #1;
      start = 1'b0;
      if (done) begin
        got_done = 1'b1;
        break;
      end
    end
    check({tag, ".done_reached"}, 64'(got_done), 64'd1);
    check({tag, ".busy"}, 64'(busy), 64'd0);
    check({tag, ".pass"}, 64'(pass), 64'(halted && (mm == '0)));
    check({tag, ".timeout"}, 64'(timeout), 64'(!halted));
    check({tag, ".mismatch"}, 64'(mismatch), 64'(mm));
    check({tag, ".final_pc"}, 64'(final_pc), 64'(fpc));
    check({tag, ".cycle_count"}, 64'(cycle_count), 64'(n_end));
    check({tag, ".pc_changes"}, 64'(pc_changes), 64'(changes));
  endtask

  initial begin
    reset      = 1'b0;
    start      = 1'b0;
    pc         = '0;
    probe_data = '0;
    exp_data   = '0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("in_reset");
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("after_reset");

    trace.delete();
    for (int i = 0; i <= 10; i++) trace.push_back(32'(i * 4));
    exp_data   = {32'hDEADBEEF, 32'h0000_0001};
    probe_data = {32'hDEADBEEF, 32'h0000_0001};
    do_run("halt_pass", 0, 0);
    check("halt_pass.fixed_pc", 64'(final_pc), 64'h28);
    check("halt_pass.fixed_changes", 64'(pc_changes), 64'd10);

    probe_data = {32'hDEADBEEE, 32'h0000_0001};
    do_run("halt_fail", 0, 0);
    check("halt_fail.fixed_mask", 64'(mismatch), 64'b10);

    trace.delete();
    for (int i = 0; i < TMO + 20; i++) trace.push_back(32'(i * 4));
    do_run("timeout", 0, 0);
    check("timeout.fixed_cycles", 64'(cycle_count), 64'(TMO));

    do_run("mid_start", 10, 0);
    do_run("abort", 0, 20);

    for (int it = 0; it < 20; it++) begin
      int len;
      trace.delete();
      len = $urandom_range(5, 90);
      trace.push_back(32'($urandom_range(0, 255)) << 2);
      for (int i = 1; i < len; i++) begin
        int r;
        r = $urandom_range(0, 9);
        if (r < 4)      trace.push_back(trace[i - 1]);
        else if (r < 8) trace.push_back(trace[i - 1] + 32'd4);
        else            trace.push_back(32'($urandom_range(0, 15)) << 2);
      end
      exp_data   = {$urandom, $urandom};
      probe_data = exp_data;
      if ($urandom_range(0, 2) == 0) probe_data[31:0]  = probe_data[31:0] ^ 32'h1;
      if ($urandom_range(0, 2) == 0) probe_data[63:32] = probe_data[63:32] ^ 32'h8000_0000;
      do_run($sformatf("rand%0d", it), ($urandom_range(0, 1) == 1) ? $urandom_range(1, 30) : 0, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
